ex_stage: RTL

- Execute stage of the 5-stage MIPS pipeline, sitting directly downstream of the forwarding unit.
- Consumes the fa/fb selects, resolves both ALU operands, and performs the single-cycle ALU op.
- Runs an iterative multiply/divide unit that writes the HI/LO registers.
- Registers the results into the EX/MEM pipeline register. Its ex_mem_rd/ex_mem_rw outputs feed back into the forwarding unit.

---
 rtl/mips_pkg.sv | 48 ++++
 rtl/ex_stage_md_unit.sv | 136 +++++++++++++
 rtl/ex_stage.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute stage: widths, ALU op codes, forwarding selects.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mips_pkg;

  localparam int W         = 32;
  localparam int MD_CYCLES = W;

  // ALU operation encoding carried in id_ex_alu_op
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_NOR   = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd6;
  localparam logic [3:0] ALU_SLTU  = 4'd7;
  localparam logic [3:0] ALU_LUI   = 4'd8;
  localparam logic [3:0] ALU_MULT  = 4'd9;
  localparam logic [3:0] ALU_MULTU = 4'd10;
  localparam logic [3:0] ALU_DIV   = 4'd11;
  localparam logic [3:0] ALU_DIVU  = 4'd12;
  localparam logic [3:0] ALU_MFHI  = 4'd13;
  localparam logic [3:0] ALU_MFLO  = 4'd14;
  localparam logic [3:0] ALU_PASS  = 4'd15;

  // Forwarding select encoding shared by fa and fb (3 behaves like FWD_IDEX)
  localparam logic [1:0] FWD_IDEX  = 2'd0;
  localparam logic [1:0] FWD_MEMWB = 2'd1;
  localparam logic [1:0] FWD_EXMEM = 2'd2;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  // Ops that start the multiply/divide unit
  function automatic logic is_md_op(input logic [3:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

  // Ops that read HI/LO
  function automatic logic is_mf_op(input logic [3:0] op);
    return (op == ALU_MFHI) || (op == ALU_MFLO);
  endfunction

endpackage

// File: rtl/ex_stage_md_unit.sv
// Iterative shift-add multiplier / restoring divider producing HI and LO.
// Latency: MD_CYCLES iterations plus one DONE cycle after the start edge.
// Backpressure: start is ignored while busy; caller must hold off until busy falls.
module md_unit
  import mips_pkg::*;
#(
  parameter int W         = mips_pkg::W,
  parameter int MD_CYCLES = W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(MD_CYCLES - 1);

  md_state_t      state;
  logic [CW-1:0]  cnt;
  logic           is_div;
  logic           neg_res;   // product or quotient must be negated
  logic           neg_rem;   // remainder must be negated (dividend was negative)
  logic           div_zero;
  logic [W-1:0]   orig_a;
  logic [W-1:0]   mag_b_q;   // multiplicand or divisor magnitude
  logic [W-1:0]   acc_hi;    // product high half / partial remainder
  logic [W-1:0]   acc_lo;    // multiplier shifting out / quotient shifting in

  logic           sgn_op;
  logic           div_op;
  logic [W-1:0]   mag_a_in;
  logic [W-1:0]   mag_b_in;
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;
  logic           div_ge;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;

  // Operand magnitudes at start and one iteration step of each algorithm
  always_comb begin
    sgn_op    = (op == ALU_MULT) || (op == ALU_DIV);
    div_op    = (op == ALU_DIV) || (op == ALU_DIVU);
    mag_a_in  = (sgn_op && a[W-1]) ? -a : a;
    mag_b_in  = (sgn_op && b[W-1]) ? -b : b;
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b_q} : {(W+1){1'b0}});
    div_shift = {acc_hi, acc_lo[W-1]};
    div_ge    = (div_shift >= {1'b0, mag_b_q});
    div_diff  = div_shift - {1'b0, mag_b_q};
  end

  // Sign correction and divide-by-zero override of the final accumulators
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_res ? -prod : prod;
    quo_fix  = neg_res ? -acc_lo : acc_lo;
    rem_fix  = neg_rem ? -acc_hi : acc_hi;
    if (is_div) begin
      hi = div_zero ? orig_a : rem_fix;
      lo = div_zero ? {W{1'b1}} : quo_fix;
    end else begin
      hi = prod_fix[2*W-1:W];
      lo = prod_fix[W-1:0];
    end
  end

  // IDLE -> RUN (MD_CYCLES iterations) -> DONE (one cycle) -> IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= MD_IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      orig_a   <= '0;
      mag_b_q  <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state    <= MD_RUN;
            busy     <= 1'b1;
            cnt      <= '0;
            is_div   <= div_op;
            neg_res  <= sgn_op && (a[W-1] ^ b[W-1]);
            neg_rem  <= sgn_op && a[W-1];
            div_zero <= (b == '0);
            orig_a   <= a;
            mag_b_q  <= mag_b_in;
            acc_hi   <= '0;
            acc_lo   <= mag_a_in;
          end
        end
        MD_RUN: begin
          if (is_div) begin
            acc_hi <= div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
            acc_lo <= {acc_lo[W-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[W:1];
            acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
          end
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= MD_DONE;
            done  <= 1'b1;
          end
        end
        MD_DONE: begin
          state <= MD_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= MD_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, single-cycle ALU, HI/LO via iterative mul/div.
// Latency: one cycle into EX/MEM; mul/div results land in HI/LO MD_CYCLES+1 cycles after start.
// Backpressure: stall holds IF/ID and ID/EX while a mul/div/mfhi/mflo waits on a busy unit.
module ex_stage
  import mips_pkg::*;
#(
  parameter int W         = mips_pkg::W,
  parameter int MD_CYCLES = W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         id_ex_valid,
  input  logic [3:0]   id_ex_alu_op,
  input  logic         id_ex_alu_src,
  input  logic [W-1:0] id_ex_rs_data,
  input  logic [W-1:0] id_ex_rt_data,
  input  logic [W-1:0] id_ex_imm,
  input  logic [4:0]   id_ex_rd,
  input  logic         id_ex_rw,
  input  logic         id_ex_mr,
  input  logic         id_ex_mw,
  input  logic [1:0]   fa,
  input  logic [1:0]   fb,
  input  logic [W-1:0] mem_wb_data,
  output logic         stall,
  output logic [W-1:0] ex_mem_alu_result,
  output logic [W-1:0] ex_mem_rt_data,
  output logic [4:0]   ex_mem_rd,
  output logic         ex_mem_rw,
  output logic         ex_mem_mr,
  output logic         ex_mem_mw,
  output logic         md_busy
);

  logic [W-1:0] fwd_a;
  logic [W-1:0] fwd_b;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] op_a_e;
  logic [W-1:0] op_b_e;
  logic [W-1:0] rt_e;
  logic [W-1:0] alu_res;
  logic         held;
  logic [W-1:0] hold_a;
  logic [W-1:0] hold_b;
  logic [W-1:0] hold_rt;
  logic [W-1:0] hi_q;
  logic [W-1:0] lo_q;
  logic         md_op;
  logic         md_start;
  logic         md_done;
  logic [W-1:0] md_hi;
  logic [W-1:0] md_lo;

  // Forwarding muxes; held copies replace live values once a stall has begun
  always_comb begin
    case (fa)
      FWD_MEMWB: fwd_a = mem_wb_data;
      FWD_EXMEM: fwd_a = ex_mem_alu_result;
      default:   fwd_a = id_ex_rs_data;
    endcase
    case (fb)
      FWD_MEMWB: fwd_b = mem_wb_data;
      FWD_EXMEM: fwd_b = ex_mem_alu_result;
      default:   fwd_b = id_ex_rt_data;
    endcase
    op_a   = fwd_a;
    op_b   = id_ex_alu_src ? id_ex_imm : fwd_b;
    op_a_e = held ? hold_a  : op_a;
    op_b_e = held ? hold_b  : op_b;
    rt_e   = held ? hold_rt : fwd_b;
  end

  // Stall and mul/div start decode
  always_comb begin
    md_op    = is_md_op(id_ex_alu_op);
    stall    = id_ex_valid && md_busy && (md_op || is_mf_op(id_ex_alu_op));
    md_start = id_ex_valid && md_op && !stall && !md_busy;
  end

  // Single-cycle ALU; mul/div ops produce 0 here since their result goes to HI/LO
  always_comb begin
    alu_res = '0;
    case (id_ex_alu_op)
      ALU_ADD:  alu_res = op_a_e + op_b_e;
      ALU_SUB:  alu_res = op_a_e - op_b_e;
      ALU_AND:  alu_res = op_a_e & op_b_e;
      ALU_OR:   alu_res = op_a_e | op_b_e;
      ALU_XOR:  alu_res = op_a_e ^ op_b_e;
      ALU_NOR:  alu_res = ~(op_a_e | op_b_e);
      ALU_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(op_a_e) < $signed(op_b_e))};
      ALU_SLTU: alu_res = {{(W-1){1'b0}}, (op_a_e < op_b_e)};
      ALU_LUI:  alu_res = op_b_e << 16;
      ALU_MFHI: alu_res = hi_q;
      ALU_MFLO: alu_res = lo_q;
      ALU_PASS: alu_res = op_a_e;
      default:  alu_res = '0;
    endcase
  end

  // Capture operands on the first stall cycle; forwarding sources drain while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held    <= 1'b0;
      hold_a  <= '0;
      hold_b  <= '0;
      hold_rt <= '0;
    end else if (stall && !held) begin
      held    <= 1'b1;
      hold_a  <= op_a;
      hold_b  <= op_b;
      hold_rt <= fwd_b;
    end else if (!stall) begin
      held    <= 1'b0;
    end
  end

  // HI/LO are written on the edge the unit finishes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (md_done) begin
      hi_q <= md_hi;
      lo_q <= md_lo;
    end
  end

  // EX/MEM pipeline register; bubbles when empty or stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_mem_alu_result <= '0;
      ex_mem_rt_data    <= '0;
      ex_mem_rd         <= '0;
      ex_mem_rw         <= 1'b0;
      ex_mem_mr         <= 1'b0;
      ex_mem_mw         <= 1'b0;
    end else if (!id_ex_valid || stall) begin
      ex_mem_alu_result <= '0;
      ex_mem_rt_data    <= '0;
      ex_mem_rd         <= '0;
      ex_mem_rw         <= 1'b0;
      ex_mem_mr         <= 1'b0;
      ex_mem_mw         <= 1'b0;
    end else begin
      ex_mem_alu_result <= md_op ? '0 : alu_res;
      ex_mem_rt_data    <= rt_e;
      ex_mem_rd         <= id_ex_rd;
      ex_mem_rw         <= id_ex_rw && !md_op;
      ex_mem_mr         <= id_ex_mr;
      ex_mem_mw         <= id_ex_mw;
    end
  end

  md_unit #(
    .W         (W),
    .MD_CYCLES (MD_CYCLES)
  ) u_md (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .op    (id_ex_alu_op),
    .a     (op_a_e),
    .b     (op_b_e),
    .busy  (md_busy),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo)
  );

endmodule
